ps2_note_voice_scheduler: RTL and testbench
===========================================

Name: ps2_note_voice_scheduler

Overview:
- Sits between the PS/2 byte receiver and the tone generators of the piano.
- Consumes received scan-code bytes (set 2) and decodes make/break prefixes.
- Maps piano keys to note indices and allocates notes across VOICES shared tone-generator slots.
- Each slot exposes an on flag and a 4-bit note index to its tone generator.

Parameters:
- VOICES, 4, number of tone-generator slots (1..8).
- TIMEOUT_CYC, 50000, idle clk cycles after a prefix byte before the prefix is discarded (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_valid  in  1  one-cycle strobe: code holds a newly received byte.
- code  in  8  received scan-code byte.
- voice_on  out  VOICES  bit i = slot i is sounding.
- voice_note  out  4*VOICES  bits [4i+3:4i] = note index of slot i.
- ovf  out  1  one-cycle pulse: a make was dropped because all slots were busy.
- prefix_to  out  1  one-cycle pulse: a pending prefix was discarded by timeout.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low clears all state immediately: voice_on=0, voice_note=0, ovf=0, prefix_to=0, FSM=IDLE, timeout counter=0.
- Key map (code -> note):
  - 1C->0, 1D->1, 1B->2, 24->3, 23->4, 2B->5, 2C->6, 34->7, 35->8, 33->9, 3C->10, 3B->11, 42->12.
  - All other non-prefix codes are unmapped and are ignored without error.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXTBRK (E0 F0 seen). Transitions happen only on code_valid.
  - IDLE: F0->BRK; E0->EXT; mapped code -> make(note), stay IDLE; anything else -> IDLE.
  - BRK: mapped code -> break(note); any byte -> IDLE. A second F0 also -> IDLE.
  - EXT: F0->EXTBRK; any other byte is consumed and ignored -> IDLE.
  - EXTBRK: any byte is consumed and ignored -> IDLE.
- Timeout:
  - The counter clears on every code_valid and increments each cycle while the FSM is not IDLE.
  - When the count reaches TIMEOUT_CYC-1: FSM->IDLE, prefix_to pulses for 1 cycle, counter clears.
  - In IDLE the counter holds 0.
  - If code_valid arrives in the same cycle as the timeout, the byte wins: it is processed in the current state and no prefix_to pulse is issued.
- make(n):
  - If some slot already has voice_on=1 with voice_note=n (typematic repeat): no change.
  - Otherwise the lowest-index slot with voice_on=0 takes voice_note=n and voice_on=1.
  - If no slot is free: no slot changes and ovf pulses for 1 cycle.
- break(n):
  - The slot holding n with voice_on=1 gets voice_on=0 and voice_note=0.
  - If no slot holds n: no change and no error.
- Latency: voice_on, voice_note, ovf and prefix_to all update on the clock edge at the end of the code_valid cycle, i.e. they are visible 1 cycle after the strobe. All outputs are registered.
- Invariant: a note occupies at most one slot at any time.
- Free slots always read voice_note=0.
- code_valid held high for k cycles is treated as k separate bytes; upstream must deliver single-cycle strobes.
- Reset asserted mid-sequence (e.g. in BRK) discards the prefix and releases all slots. No output pulse is generated by reset.

Test Plan:
- Reset, then bytes 1C, 1B -> voice_on=0011; slot0 note=0, slot1 note=2; ovf=0.
- Bytes 1C, 1C, 1C (repeat) -> only slot0 on with note 0; no other slot claimed.
- VOICES=4; makes 1C,1D,1B,24, then make 23 -> voice_on=1111, ovf pulses once, slot notes stay 0,1,2,3. Then F0 1D -> slot1 off with note 0. Then make 23 -> slot1 on with note 4.
- E0 F0 1C while slot0 holds note 0 -> no change (extended break ignored). Then F0 1C -> slot0 off.
- F0, then no byte for TIMEOUT_CYC cycles -> prefix_to pulses exactly once, FSM in IDLE. A following 1C is treated as a make (slot takes note 0), not a break.
- Slots 0 and 1 on, F0 pending; assert rst_n low mid-cycle asynchronously -> voice_on=0 immediately. After release, byte 1C makes note 0 in slot0.

Source files
------------

// File: rtl/ps2_note_voice_scheduler_if.sv
// Scan-code byte input and tone-generator slot outputs of the note voice scheduler.
interface ps2_note_voice_scheduler_if #(
    parameter int unsigned VOICES = 4
);
    logic                  code_valid;
    logic [7:0]            code;
    logic [VOICES-1:0]     voice_on;
    logic [4*VOICES-1:0]   voice_note;
    logic                  ovf;
    logic                  prefix_to;

    modport master (
        output code_valid, code,
        input  voice_on, voice_note, ovf, prefix_to
    );

    modport slave (
        input  code_valid, code,
        output voice_on, voice_note, ovf, prefix_to
    );
endinterface

// File: rtl/ps2_note_voice_scheduler.sv
// Decodes PS/2 set-2 make/break sequences for the piano keys and allocates
// the resulting notes across VOICES shared tone-generator slots.
module ps2_note_voice_scheduler #(
    parameter int unsigned VOICES      = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ps2_note_voice_scheduler_if.slave     bus
);
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BRK    = 2'd1;
    localparam logic [1:0] S_EXT    = 2'd2;
    localparam logic [1:0] S_EXTBRK = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VOICES-1:0]     on_q, on_d;
    logic [4*VOICES-1:0]   note_q, note_d;
    logic                  ovf_q, ovf_d;
    logic                  pto_q, pto_d;

    logic [4:0]            km;
    logic [VOICES-1:0]     hit_oh;
    logic [VOICES-1:0]     freev;
    logic [VOICES-1:0]     free_oh;
    logic                  do_make;
    logic                  do_brk;

    // Returns {mapped, note} for a scan code.
    function automatic logic [4:0] key_map(input logic [7:0] c);
        case (c)
            8'h1C:   key_map = {1'b1, 4'd0};
            8'h1D:   key_map = {1'b1, 4'd1};
            8'h1B:   key_map = {1'b1, 4'd2};
            8'h24:   key_map = {1'b1, 4'd3};
            8'h23:   key_map = {1'b1, 4'd4};
            8'h2B:   key_map = {1'b1, 4'd5};
            8'h2C:   key_map = {1'b1, 4'd6};
            8'h34:   key_map = {1'b1, 4'd7};
            8'h35:   key_map = {1'b1, 4'd8};
            8'h33:   key_map = {1'b1, 4'd9};
            8'h3C:   key_map = {1'b1, 4'd10};
            8'h3B:   key_map = {1'b1, 4'd11};
            8'h42:   key_map = {1'b1, 4'd12};
            default: key_map = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            on_q    <= '0;
            note_q  <= '0;
            ovf_q   <= 1'b0;
            pto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            note_q  <= note_d;
            ovf_q   <= ovf_d;
            pto_q   <= pto_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        note_d  = note_q;
        ovf_d   = 1'b0;
        pto_d   = 1'b0;
        do_make = 1'b0;
        do_brk  = 1'b0;
        km      = key_map(bus.code);
        hit_oh  = '0;
        for (int i = 0; i < int'(VOICES); i++) begin
            if (on_q[i] && (note_q[4*i +: 4] == km[3:0])) hit_oh[i] = 1'b1;
        end
        // Lowest free slot as a one-hot mask.
        freev   = ~on_q;
        free_oh = freev & (~freev + VOICES'(1));

        if (bus.code_valid) begin
            cnt_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.code == 8'hF0)      state_d = S_BRK;
                    else if (bus.code == 8'hE0) state_d = S_EXT;
                    else                        do_make = km[4];
                end
                S_BRK: begin
                    do_brk  = km[4];
                    state_d = S_IDLE;
                end
                S_EXT:   state_d = (bus.code == 8'hF0) ? S_EXTBRK : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                state_d = S_IDLE;
                pto_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = CW'(cnt_q + 1'b1);
            end
        end else begin
            cnt_d = '0;
        end

        // A repeat of a sounding note leaves every slot untouched.
        if (do_make && (hit_oh == '0)) begin
            if (freev == '0) begin
                ovf_d = 1'b1;
            end else begin
                on_d = on_q | free_oh;
                for (int i = 0; i < int'(VOICES); i++) begin
                    if (free_oh[i]) note_d[4*i +: 4] = km[3:0];
                end
            end
        end

        if (do_brk) begin
            for (int i = 0; i < int'(VOICES); i++) begin
                if (hit_oh[i]) begin
                    on_d[i]          = 1'b0;
                    note_d[4*i +: 4] = 4'd0;
                end
            end
        end
    end

    assign bus.voice_on   = on_q;
    assign bus.voice_note = note_q;
    assign bus.ovf        = ovf_q;
    assign bus.prefix_to  = pto_q;
endmodule

// File: tb/tb_ps2_note_voice_scheduler.sv
// Scoreboard bench for the PS/2 note voice scheduler: a slot/prefix model predicts
// every byte's outcome, plus directed checks of timeout and asynchronous reset.
module tb_ps2_note_voice_scheduler;
    localparam int unsigned VOICES = 4;
    localparam int unsigned TO     = 20;

    typedef struct packed {
        logic [VOICES-1:0]   on;
        logic [4*VOICES-1:0] note;
        logic                ovf;
        logic                pto;
    } exp_t;

    logic clk;
    logic rst_n;
    ps2_note_voice_scheduler_if #(.VOICES(VOICES)) bus ();

    ps2_note_voice_scheduler #(.VOICES(VOICES), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    int       m_st;
    logic     m_on   [VOICES];
    int       m_note [VOICES];
    logic [7:0] keys [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                              8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_st = 0;
        for (int i = 0; i < VOICES; i++) begin
            m_on[i]   = 1'b0;
            m_note[i] = 0;
        end
    endtask

    // Predicts the slot state after one byte and queues it.
    task automatic model_byte(input logic [7:0] b);
        int   n;
        logic ovf_e;
        logic found;
        exp_t e;
        n = -1;
        ovf_e = 1'b0;
        for (int k = 0; k < 13; k++) if (keys[k] == b) n = k;
        case (m_st)
            0: begin
                if (b == 8'hF0) m_st = 1;
                else if (b == 8'hE0) m_st = 2;
                else if (n >= 0) begin
                    found = 1'b0;
                    for (int i = 0; i < VOICES; i++) if (m_on[i] && m_note[i] == n) found = 1'b1;
                    if (!found) begin
                        for (int i = 0; i < VOICES; i++) begin
                            if (!found && !m_on[i]) begin
                                m_on[i] = 1'b1;
                                m_note[i] = n;
                                found = 1'b1;
                            end
                        end
                        if (!found) ovf_e = 1'b1;
                    end
                end
            end
            1: begin
                if (n >= 0) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (m_on[i] && m_note[i] == n) begin
                            m_on[i] = 1'b0;
                            m_note[i] = 0;
                        end
                    end
                end
                m_st = 0;
            end
            2: m_st = (b == 8'hF0) ? 3 : 0;
            default: m_st = 0;
        endcase
        for (int i = 0; i < VOICES; i++) begin
            e.on[i] = m_on[i];
            e.note[4*i +: 4] = 4'(m_note[i]);
        end
        e.ovf = ovf_e;
        e.pto = 1'b0;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        bus.code       = b;
        bus.code_valid = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        bus.code_valid = 1'b0;
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("on_%02h", b),   32'(bus.voice_on),   32'(e.on));
            chk($sformatf("note_%02h", b), 32'(bus.voice_note), 32'(e.note));
            chk($sformatf("ovf_%02h", b),  32'(bus.ovf),        32'(e.ovf));
            chk($sformatf("pto_%02h", b),  32'(bus.prefix_to),  32'(e.pto));
        end
    endtask

    initial begin
        int pulses;
        rst_n          = 1'b0;
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_on",   32'(bus.voice_on),   32'd0);
        chk("rst_note", 32'(bus.voice_note), 32'd0);
        chk("rst_ovf",  32'(bus.ovf),        32'd0);
        chk("rst_pto",  32'(bus.prefix_to),  32'd0);
        rst_n = 1'b1;

        send(8'h1C); send(8'h1B);
        chk("two_on",   32'(bus.voice_on),   32'h3);
        chk("two_note", 32'(bus.voice_note), 32'h0020);
        send(8'hF0); send(8'h1B);
        send(8'h1C); send(8'h1C);
        chk("rep_on", 32'(bus.voice_on), 32'h1);

        send(8'h1D); send(8'h1B); send(8'h24);
        send(8'h23);
        chk("ovf_pulse", 32'(bus.ovf),        32'd1);
        chk("full_note", 32'(bus.voice_note), 32'h3210);
        send(8'hF0); send(8'h1D);
        chk("brk1_on", 32'(bus.voice_on), 32'hD);
        send(8'h23);
        chk("reuse_note", 32'(bus.voice_note), 32'h3240);

        send(8'hE0); send(8'hF0); send(8'h1C);
        chk("extbrk_on", 32'(bus.voice_on), 32'hF);
        send(8'hE0); send(8'h1C);
        send(8'h15);
        send(8'hF0); send(8'h1C);
        chk("brk0_on", 32'(bus.voice_on), 32'hE);
        send(8'h1C);

        // Byte arriving on the timeout cycle is still a break.
        send(8'hF0);
        repeat (TO - 1) @(posedge clk);
        send(8'h1C);
        pulses = 0;
        repeat (TO + 4) begin
            @(negedge clk);
            if (bus.prefix_to) pulses++;
        end
        chk("race_no_pto", 32'(pulses), 32'd0);

        send(8'hF0);
        pulses = 0;
        repeat (TO + 4) begin
            @(negedge clk);
            if (bus.prefix_to) pulses++;
        end
        chk("pto_once", 32'(pulses), 32'd1);
        m_st = 0;
        send(8'h1C);
        chk("after_to_make", 32'(bus.voice_on), 32'hF);

        send(8'hF0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_on",   32'(bus.voice_on),   32'd0);
        chk("async_note", 32'(bus.voice_note), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h1C);
        chk("post_rst_on", 32'(bus.voice_on), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
